ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction-fetch initiator for the pipeline's IF stage. It owns the program counter and drives it onto the combinational instruction-memory port. Each cycle it captures the returned instruction word and its fault flags into a small output buffer. It then presents entries to decode through a valid/ready handshake, and takes redirects (branch, jump or trap) through a flush port.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: value loaded into the PC on reset. It must be 4-byte aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- flush_i  input  1  redirect request; has priority over all other activity.
- flush_pc_i  input  `PC_WIDTH  redirect target.
- pc_o  output  `PC_WIDTH  fetch address to the instruction-memory port; equal to pc_r.
- instr_i  input  `INSTR_WIDTH  instruction word for pc_o, valid in the same cycle.
- pc_misalign_i  input  1  misalignment flag from the memory port for pc_o.
- bus_err_i  input  1  bus-error flag from the memory port for pc_o.
- valid_o  output  1  the buffer head holds a fetched entry.
- ready_i  input  1  decode accepts the head entry this cycle.
- instr_o  output  `INSTR_WIDTH  head entry's instruction.
- pc_out_o  output  `PC_WIDTH  head entry's PC.
- exc_misalign_o  output  1  head entry's misalign flag.
- exc_bus_err_o  output  1  head entry's bus-error flag.

## Operation
- State machine, two states:
  - RUN: fetching.
  - HALT: a faulting fetch has been captured, and fetching is stopped until the next flush.
- pop = valid_o & ready_i.
- fetch = (state==RUN) & !flush_i & (count<DEPTH | pop).
- On fetch:
  - Capture {pc_r, instr_i, pc_misalign_i, bus_err_i} at the buffer tail.
  - pc_r <= pc_r + 4, wrapping modulo 2^`PC_WIDTH (32'hFFFF_FFFC → 0).
  - If pc_misalign_i | bus_err_i, move to HALT. That entry is still enqueued, and pc_r still increments.
- On pop: the head entry is removed. A pop and a fetch in the same cycle leave count unchanged.
- On flush_i:
  - Buffer is emptied; any pop that cycle is ignored and count becomes 0.
  - pc_r <= flush_pc_i and state <= RUN.
  - No capture that cycle.
- A misaligned flush_pc_i is accepted as-is. The fault is reported through pc_misalign_i on the following fetch.
- The buffer is in-order with a count of 0..DEPTH. The output fields show the head entry, and are 0 when the buffer is empty.
- When the buffer is full and there is no pop, pc_r holds and pc_o stays stable.

## Timing
- Reset (rst=1 at an edge):
  - pc_r = RESET_PC, state = RUN, count = 0.
  - valid_o = 0; instr_o, pc_out_o and both exc flags = 0.
- Fetch to valid: the word fetched for pc_o in cycle t appears on valid_o and instr_o in cycle t+1.
- First valid_o after rst deasserts: the cycle after the first non-reset edge.
- flush_i high in cycle t:
  - valid_o = 0 in t+1.
  - pc_o = flush_pc_i in t+1.
  - First redirected entry valid in t+2.
- rst high mid-operation overrides flush_i and any handshake. Buffered entries are discarded.
- Sustained throughput is one instruction per cycle while ready_i=1, at any DEPTH.
- With ready_i=0, the buffer fills in DEPTH cycles, after which pc_o freezes.

## Configuration
- IFU_BUF2_EN defined:
  - DEPTH = 2, a two-entry circular buffer with rd/wr pointers.
  - A fetch may proceed while one entry is waiting and ready_i=0.
- IFU_BUF2_EN undefined:
  - DEPTH = 1, a single holding register.
  - Fetch when empty or when popping in the same cycle.
  - Same-cycle fetch and pop replaces the entry.
- Handshake, flush and HALT behaviour are identical in both builds.

## Structure
- `PC_WIDTH and `INSTR_WIDTH come from defines.v.
- Add to defines.v:
  - `IFU_ST_RUN and `IFU_ST_HALT state encodings.
  - `IFU_PC_INC = 4.
  - `IFU_ENTRY_WIDTH = PC_WIDTH + INSTR_WIDTH + 2.
- One sub-module is natural: ifu_buf, the parameterised DEPTH 1/2 entry buffer with push, pop, clear, full, empty and head.
- The PC register and state machine stay in ifu_fetch.

## Test plan
- Reset, then ready_i=1 with memory returning instr = pc ^ 32'hA5A5_A5A5:
  - pc_out_o runs 0, 4, 8, 12 on consecutive cycles.
  - instr_o matches.
  - valid_o=1 continuously from cycle 1.
- ready_i=0 for 5 cycles after 2 fetches:
  - pc_o freezes at 8 (IFU_BUF2_EN) or 4 (without).
  - The head entry stays pc 0.
  - On ready_i=1, entries appear in order without loss.
- flush_i in the same cycle as a pop, with flush_pc_i = 32'h100:
  - Next cycle valid_o=0 and pc_o = 32'h100.
  - The cycle after that, pc_out_o = 32'h100.
- bus_err_i=1 at pc 8:
  - The entry at 8 carries exc_bus_err_o=1.
  - No further entries are produced.
  - pc_o holds at 12 until flush_i, which resumes fetching.
- Flush to 32'h102: the entry shows pc_out_o = 32'h102 with exc_misalign_o=1, then HALT.
- Flush to 32'hFFFF_FFFC: entries show FFFF_FFFC, then 0 (wrap).
- rst asserted with a full buffer: valid_o=0 and pc_o = RESET_PC on the next cycle.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Types and constants shared by ifu_fetch and ifu_buf.
// Build option: IFU_BUF2_EN selects a two-entry output buffer, otherwise a
// single holding register.
`include "defines.v"

package ifu_fetch_pkg;

  localparam int PC_W    = `PC_WIDTH;
  localparam int INSTR_W = `INSTR_WIDTH;

`ifdef IFU_BUF2_EN
  localparam int IFU_DEPTH = 2;
`else
  localparam int IFU_DEPTH = 1;
`endif

  localparam logic [0:0] ST_RUN  = `IFU_ST_RUN;
  localparam logic [0:0] ST_HALT = `IFU_ST_HALT;

  localparam logic [PC_W-1:0] PC_INC = PC_W'(`IFU_PC_INC);

  // One captured fetch: address, word and the two memory-port fault flags.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               misalign;
    logic               bus_err;
  } ifu_entry_t;

endpackage

// File: rtl/defines.v
// Shared width and encoding defines for the IF stage.
//   PC_WIDTH / INSTR_WIDTH : fetch address and instruction word widths
//   IFU_ST_RUN / IFU_ST_HALT : ifu_fetch state encodings
//   IFU_PC_INC : sequential PC step in bytes
//   IFU_ENTRY_WIDTH : packed width of one buffered fetch entry
`ifndef IFU_DEFINES_V
`define IFU_DEFINES_V

`define PC_WIDTH        32
`define INSTR_WIDTH     32
`define IFU_ST_RUN      1'b0
`define IFU_ST_HALT     1'b1
`define IFU_PC_INC      4
`define IFU_ENTRY_WIDTH (`PC_WIDTH + `INSTR_WIDTH + 2)

`endif

// File: rtl/ifu_buf.sv
// In-order fetch-entry buffer, DEPTH 1 (holding register) or 2 (circular).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clear           : drop all entries; wins over push/pop
//   push, push_data : enqueue at tail (caller guarantees !full | pop)
//   pop             : dequeue head (caller guarantees !empty)
//   full, empty     : occupancy status
//   head            : head entry, all-zero when empty
`include "defines.v"

module ifu_buf
  import ifu_fetch_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  ifu_entry_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output ifu_entry_t head
);

  generate
    if (DEPTH == 1) begin : g_d1
      ifu_entry_t ent;
      logic       vld;

      // Push with a simultaneous pop simply overwrites the held entry.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          vld <= 1'b0;
        end else if (push) begin
          vld <= 1'b1;
        end else if (pop) begin
          vld <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (push && !clear) ent <= push_data;
      end

      assign full  = vld;
      assign empty = !vld;
      assign head  = vld ? ent : '0;
    end else begin : g_d2
      ifu_entry_t mem [0:1];
      logic [1:0] cnt;
      logic       wr_ptr;
      logic       rd_ptr;

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          cnt    <= 2'd0;
          wr_ptr <= 1'b0;
          rd_ptr <= 1'b0;
        end else begin
          if (push) wr_ptr <= ~wr_ptr;
          if (pop)  rd_ptr <= ~rd_ptr;
          case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
          endcase
        end
      end

      // Storage is not reset; head is masked while empty.
      always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
      end

      assign full  = (cnt == 2'd2);
      assign empty = (cnt == 2'd0);
      assign head  = empty ? '0 : mem[rd_ptr];
    end
  endgenerate

endmodule

// File: rtl/ifu_fetch.sv
// IF-stage fetch initiator. Owns the PC, drives the combinational
// instruction-memory port, buffers returned words and hands them to decode
// over valid/ready. A faulting fetch is still delivered but stops fetching
// (HALT) until the next flush redirects the PC.
// Build option: IFU_BUF2_EN (two-entry buffer instead of one).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   flush_i, flush_pc_i               : redirect; overrides all but reset
//   pc_o                              : fetch address to memory
//   instr_i, pc_misalign_i, bus_err_i : memory response for pc_o, same cycle
//   valid_o, ready_i                  : decode handshake
//   instr_o, pc_out_o, exc_*_o        : head entry fields, 0 when empty
`include "defines.v"

module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    flush_pc_i,
  output logic [PC_W-1:0]    pc_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               pc_misalign_i,
  input  logic               bus_err_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_out_o,
  output logic               exc_misalign_o,
  output logic               exc_bus_err_o
);

  logic [PC_W-1:0] pc_r;
  logic [0:0]      state;
  logic            buf_full;
  logic            buf_empty;
  logic            pop;
  logic            fetch;
  ifu_entry_t      new_ent;
  ifu_entry_t      head;

  assign pop   = valid_o && ready_i;
  // A pop frees a slot in the same cycle, so a full buffer still streams.
  assign fetch = (state == ST_RUN) && !flush_i && (!buf_full || pop);

  assign new_ent = '{pc: pc_r, instr: instr_i,
                     misalign: pc_misalign_i, bus_err: bus_err_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r  <= RESET_PC;
      state <= ST_RUN;
    end else if (flush_i) begin
      pc_r  <= flush_pc_i;
      state <= ST_RUN;
    end else if (fetch) begin
      pc_r <= pc_r + PC_INC;
      if (pc_misalign_i || bus_err_i) state <= ST_HALT;
    end
  end

  ifu_buf #(.DEPTH(IFU_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (fetch),
    .push_data (new_ent),
    .pop       (pop),
    .full      (buf_full),
    .empty     (buf_empty),
    .head      (head)
  );

  assign pc_o           = pc_r;
  assign valid_o        = !buf_empty;
  assign instr_o        = head.instr;
  assign pc_out_o       = head.pc;
  assign exc_misalign_o = head.misalign;
  assign exc_bus_err_o  = head.bus_err;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: queue-based reference model checked every
// cycle, plus literal expectations along the test plan.
module tb_ifu_fetch;

`ifdef IFU_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] XMASK = 32'hA5A5_A5A5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
    logic        err;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush_i, ready_i;
  logic [31:0] flush_pc_i, pc_o, instr_i, instr_o, pc_out_o;
  logic        pc_misalign_i, bus_err_i, valid_o, exc_misalign_o, exc_bus_err_o;
  logic [31:0] err_pc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instruction memory: word is a fixed function of the address.
  assign instr_i       = pc_o ^ XMASK;
  assign pc_misalign_i = |pc_o[1:0];
  assign bus_err_i     = (pc_o == err_pc);

  ifu_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .pc_o(pc_o), .instr_i(instr_i), .pc_misalign_i(pc_misalign_i),
    .bus_err_i(bus_err_i), .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_out_o(pc_out_o),
    .exc_misalign_o(exc_misalign_o), .exc_bus_err_o(exc_bus_err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of fetched entries and a next-PC.
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_on = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete(); m_pc = 32'h0; m_halt = 0; m_on = 1;
      end else if (flush_i) begin
        q.delete(); m_pc = flush_pc_i; m_halt = 0;
      end else if (m_on) begin
        bit   p, f;
        ent_t e;
        p = (q.size() > 0) && ready_i;
        f = !m_halt && ((q.size() < DEPTH) || p);
        if (p) void'(q.pop_front());
        if (f) begin
          e.pc = m_pc; e.instr = m_pc ^ XMASK;
          e.mis = (m_pc % 4) != 0; e.err = (m_pc == err_pc);
          q.push_back(e);
          if (e.mis || e.err) m_halt = 1;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_on) begin
        chk("m_pc_o", pc_o, m_pc);
        chk("m_valid", {31'd0, valid_o}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
          chk("m_pc_out", pc_out_o, q[0].pc);
          chk("m_instr", instr_o, q[0].instr);
          chk("m_flags", {30'd0, exc_misalign_o, exc_bus_err_o}, {30'd0, q[0].mis, q[0].err});
        end else begin
          chk("m_empty_fields", pc_out_o | instr_o | {30'd0, exc_misalign_o, exc_bus_err_o}, 32'h0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    flush_i = 1; flush_pc_i = tgt;
    step();
    flush_i = 0;
  endtask

  initial begin
    rst = 1; flush_i = 0; flush_pc_i = 0; ready_i = 0; err_pc = 32'hDEAD_BEE0;
    @(negedge clk);
    step();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_fields", pc_out_o | instr_o | {30'd0, exc_misalign_o, exc_bus_err_o}, 32'h0);

    // Streaming at one per cycle.
    rst = 0; ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_valid", {31'd0, valid_o}, 32'd1);
      chk("stream_pc", pc_out_o, 32'(i * 4));
      chk("stream_instr", instr_o, 32'(i * 4) ^ 32'hA5A5_A5A5);
    end

    // Backpressure: buffer fills, PC freezes, then drains in order.
    do_flush(32'h0);
    chk("fl0_valid", {31'd0, valid_o}, 32'd0);
    ready_i = 0;
    for (int i = 0; i < 6; i++) step();
    chk("bp_pc_o", pc_o, (DEPTH == 2) ? 32'h8 : 32'h4);
    chk("bp_head", pc_out_o, 32'h0);
    ready_i = 1;
    chk("drain0", pc_out_o, 32'h0);
    step(); chk("drain1", pc_out_o, 32'h4);
    step(); chk("drain2", pc_out_o, 32'h8);

    // Flush coinciding with a pop.
    do_flush(32'h100);
    chk("flpop_valid", {31'd0, valid_o}, 32'd0);
    chk("flpop_pc_o", pc_o, 32'h100);
    step();
    chk("flpop_head", pc_out_o, 32'h100);

    // Bus error at 8 halts fetching.
    err_pc = 32'h8;
    do_flush(32'h0);
    step(); step(); step();
    chk("berr_pc", pc_out_o, 32'h8);
    chk("berr_flag", {31'd0, exc_bus_err_o}, 32'd1);
    chk("berr_pc_o", pc_o, 32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_valid", {31'd0, valid_o}, 32'd0);
      chk("halt_pc_o", pc_o, 32'hC);
    end
    err_pc = 32'hDEAD_BEE0;
    do_flush(32'h200);
    step();
    chk("resume_head", pc_out_o, 32'h200);

    // Misaligned redirect.
    do_flush(32'h102);
    step();
    chk("mis_pc", pc_out_o, 32'h102);
    chk("mis_flag", {31'd0, exc_misalign_o}, 32'd1);
    step(); step();
    chk("mis_halt_valid", {31'd0, valid_o}, 32'd0);
    chk("mis_halt_pc_o", pc_o, 32'h106);

    // Address wrap.
    do_flush(32'hFFFF_FFFC);
    step(); chk("wrap0", pc_out_o, 32'hFFFF_FFFC);
    step(); chk("wrap1", pc_out_o, 32'h0);

    // Reset with a full buffer.
    do_flush(32'h40);
    ready_i = 0;
    for (int i = 0; i < 3; i++) step();
    chk("full_valid", {31'd0, valid_o}, 32'd1);
    rst = 1; flush_i = 1; flush_pc_i = 32'h300; ready_i = 1;
    step();
    rst = 0; flush_i = 0;
    chk("rst2_valid", {31'd0, valid_o}, 32'd0);
    chk("rst2_pc_o", pc_o, 32'h0);
    step();
    chk("rst2_head", pc_out_o, 32'h0);

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
